// File: rtl/layer_act_collect.sv
// Requantizes accumulator results and packs N_OUT of them into ping-pong vector banks.
// Vector valid the cycle after its last accept; in_ready drops only when both banks are full.
module layer_act_collect #(
  parameter int N_OUT   = 16,
  parameter int ACC_W   = 32,
  parameter int DW      = 16,
  parameter int SHIFT   = 8,
  parameter int RELU_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACC_W-1:0]      in_acc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_OUT*DW-1:0]   out_vec,
  output logic                  out_sat
);

  localparam int IW     = $clog2(N_OUT);
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND  = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-DW){1'b1}}, {(DW-1){1'b0}}};

  logic [IW-1:0]        wr_idx_q, wr_idx_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [1:0]           full_q, full_d;
  logic [1:0]           sat_q, sat_d;
  logic [N_OUT*DW-1:0]  bank_q [2];

  logic signed [ACC_W:0] acc_ext, r_val, q_val, q_relu;
  logic [DW-1:0]         elem;
  logic                  elem_sat;
  logic                  accept, drain;

  // One extra bit of headroom so the rounding add cannot overflow.
  always_comb begin
    acc_ext  = {in_acc[ACC_W-1], in_acc};
    r_val    = acc_ext + RND;
    q_val    = r_val >>> SHIFT;
    q_relu   = ((RELU_EN != 0) && (q_val < 0)) ? '0 : q_val;
    elem     = q_relu[DW-1:0];
    elem_sat = 1'b0;
    if (q_relu > MAXV) begin
      elem     = MAXV[DW-1:0];
      elem_sat = 1'b1;
    end else if (q_relu < MINV) begin
      elem     = MINV[DW-1:0];
      elem_sat = 1'b1;
    end
  end

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_vec   = bank_q[rd_bank_q];
  assign out_sat   = sat_q[rd_bank_q];

  assign accept = in_valid && in_ready && !flush;
  assign drain  = out_valid && out_ready;

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    sat_d     = sat_q;
    if (flush) begin
      wr_idx_d = '0;
      // A full bank under the write pointer is waiting to drain; leave its flag alone.
      if (!full_q[wr_bank_q]) sat_d[wr_bank_q] = 1'b0;
    end else if (accept) begin
      sat_d[wr_bank_q] = sat_q[wr_bank_q] | elem_sat;
      if (wr_idx_q == IW'(N_OUT - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = IW'(wr_idx_q + 1'b1);
      end
    end
    if (drain) begin
      full_d[rd_bank_q] = 1'b0;
      sat_d[rd_bank_q]  = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      sat_q     <= '0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      sat_q     <= sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
    end else if (accept) begin
      bank_q[wr_bank_q][wr_idx_q*DW +: DW] <= elem;
    end
  end

endmodule

// File: tb/tb_layer_act_collect.sv
// Directed checks of requantization, packing, ping-pong backpressure, flush and reset.
// A second instance with ReLU disabled shares the stimulus for the signed/saturation cases.
module tb_layer_act_collect;

  localparam int N  = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, flush, out_ready;
  logic [31:0]   in_acc;
  logic          in_ready, out_valid, out_sat;
  logic [255:0]  out_vec;
  logic          in_ready_nr, out_valid_nr, out_sat_nr;
  logic [255:0]  out_vec_nr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  layer_act_collect #(.N_OUT(N), .ACC_W(32), .DW(DW), .SHIFT(8), .RELU_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_sat(out_sat)
  );

  layer_act_collect #(.N_OUT(N), .ACC_W(32), .DW(DW), .SHIFT(8), .RELU_EN(0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nr), .in_acc(in_acc),
    .flush(flush), .out_valid(out_valid_nr), .out_ready(out_ready), .out_vec(out_vec_nr),
    .out_sat(out_sat_nr)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ramp(input int base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 16'(base + i);
    return v;
  endfunction

  task automatic push(input logic [31:0] v);
    in_valid = 1'b1;
    in_acc   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [255:0] exp_v;
  int acc_cnt, vec_cnt, stall_cnt;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_acc = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_vec", out_vec, '0);
    check("rst_out_sat", 256'(out_sat), 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Rounding and ReLU: 384->2, 383->1, -384->0 (ReLU), 0->0, 256k->k
    push(32'd384); push(32'd383); push(-32'sd384); push(32'd0);
    for (int k = 4; k < 15; k++) push(32'(256 * k));
    check("main_valid_before_last", 256'(out_valid), 256'(0));
    push(32'(256 * 15));
    check("main_valid_after_last", 256'(out_valid), 256'(1));
    exp_v = ramp(0);
    exp_v[0*DW +: DW] = 16'd2;
    exp_v[1*DW +: DW] = 16'd1;
    exp_v[2*DW +: DW] = 16'd0;
    exp_v[3*DW +: DW] = 16'd0;
    check("main_vec", out_vec, exp_v);
    check("main_sat", 256'(out_sat), 256'(0));
    check("noRelu_elem2", 256'(out_vec_nr[2*DW +: DW]), 256'(16'hFFFF));
    drain_one();
    check("main_drained", 256'(out_valid), 256'(0));

    // Saturation at both extremes
    for (int i = 0; i < N; i++) begin
      if (i == 5) push(32'h7FFF_FFFF);
      else if (i == 6) push(32'h8000_0000);
      else push(32'd0);
    end
    check("sat_pos_elem", 256'(out_vec_nr[5*DW +: DW]), 256'(16'h7FFF));
    check("sat_neg_elem", 256'(out_vec_nr[6*DW +: DW]), 256'(16'h8000));
    check("sat_flag", 256'(out_sat_nr), 256'(1));
    check("sat_relu_elem6", 256'(out_vec[6*DW +: DW]), 256'(0));
    check("sat_relu_flag", 256'(out_sat), 256'(1));
    drain_one();
    for (int i = 0; i < N; i++) push(32'd0);
    check("sat_clear_vec", out_vec_nr, '0);
    check("sat_clear_flag", 256'(out_sat_nr), 256'(0));
    drain_one();

    // Backpressure: both banks fill, then one drain frees a bank
    acc_cnt = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_acc = 32'(acc_cnt * 256);
      @(negedge clk);
      if (in_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    check("bp_accepts", 256'(acc_cnt), 256'(32));
    check("bp_in_ready_low", 256'(in_ready), 256'(0));
    check("bp_vec_a", out_vec, ramp(0));
    in_valid = 1'b0;
    drain_one();
    check("bp_in_ready_back", 256'(in_ready), 256'(1));
    check("bp_vec_b", out_vec, ramp(16));
    check("bp_valid_b", 256'(out_valid), 256'(1));
    drain_one();
    check("bp_empty", 256'(out_valid), 256'(0));

    // Streaming 64 elements with downstream always ready
    vec_cnt = 0; stall_cnt = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 70; c++) begin
      in_valid = (c < 64);
      in_acc   = 32'(c * 256);
      @(negedge clk);
      if (in_valid && !in_ready) stall_cnt++;
      if (out_valid) begin
        check($sformatf("stream_vec%0d", vec_cnt), out_vec, ramp(16 * vec_cnt));
        vec_cnt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("stream_vectors", 256'(vec_cnt), 256'(4));
    check("stream_stalls", 256'(stall_cnt), 256'(0));

    // Flush drops the partial vector and the colliding element
    for (int i = 0; i < 7; i++) push(32'(256 * (50 + i)));
    flush = 1'b1;
    push(32'(256 * 99));
    flush = 1'b0;
    check("flush_no_valid", 256'(out_valid), 256'(0));
    for (int i = 1; i <= N; i++) push(32'(256 * i));
    check("flush_valid", 256'(out_valid), 256'(1));
    check("flush_vec", out_vec, ramp(1));
    drain_one();

    // Reset with one full bank and a partial one
    for (int i = 0; i < N + 9; i++) push(32'(256 * (200 + i)));
    check("prerst_valid", 256'(out_valid), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 256'(out_valid), 256'(0));
    check("midrst_vec", out_vec, '0);
    check("midrst_in_ready", 256'(in_ready), 256'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) push(32'(256 * (300 + i)));
    check("postrst_vec", out_vec, ramp(300));
    check("postrst_sat", 256'(out_sat), 256'(0));
    check("postrst_valid", 256'(out_valid), 256'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/layer_act_collect.md
# layer_act_collect

Downstream companion of the fully-connected neuron stage. It accepts one signed wide accumulator result per neuron and requantizes each to DW bits with round-half-up, arithmetic shift, optional ReLU and saturation. It packs N_OUT consecutive results into one layer-output vector and hands that vector to the next layer over a valid/ready handshake. Two vector banks (ping-pong) let collection of layer k+1 overlap with draining of layer k.

## Interface
- N_OUT, 16: neurons per layer, i.e. elements per output vector (≥2).
- ACC_W, 32: accumulator width of incoming results.
- DW, 16: output element width.
- SHIFT, 8: fractional bits removed by requantization (0..ACC_W-2).
- RELU_EN, 1: 1 applies ReLU before saturation; 0 bypasses it.
- Clocking: one clock; reset is asynchronous and active-low.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_acc holds a valid neuron result.
- in_ready  out  1  block can accept a result this cycle.
- in_acc  in  ACC_W  signed accumulator value.
- flush  in  1  synchronous; discards a partially filled vector.
- out_valid  out  1  out_vec holds a complete vector.
- out_ready  in  1  downstream accepts out_vec this cycle.
- out_vec  out  N_OUT*DW  element i at bits [i*DW +: DW]; element 0 is the first accepted result.
- out_sat  out  1  at least one element of the presented vector was clamped.

## Operation
- Requantization is applied to every accepted value and computed in ACC_W+1 bits with no intermediate overflow:
  - r = in_acc + 2^(SHIFT-1), or r = in_acc when SHIFT=0.
  - q = r >>> SHIFT.
  - If RELU_EN and q<0: q=0.
  - Clamp q to [-2^(DW-1), 2^(DW-1)-1]. The element's sat bit is set only when this clamp changes the value; ReLU zeroing is not saturation.
- State:
  - two banks of N_OUT×DW with a per-bank sat bit;
  - wr_bank, wr_idx (0..N_OUT-1), rd_bank;
  - full[1:0].
- in_ready = !full[wr_bank], taken directly from registers with no combinational path from out_ready.
- Accept when in_valid && in_ready:
  - write the element to bank[wr_bank][wr_idx] and OR its sat bit into the bank sat bit;
  - if wr_idx==N_OUT-1: set full[wr_bank], toggle wr_bank, wr_idx←0; otherwise increment wr_idx.
- Output side:
  - out_valid = full[rd_bank]; out_vec and out_sat show bank[rd_bank].
  - On out_valid && out_ready: clear full[rd_bank] and that bank's sat bit, toggle rd_bank.
- Simultaneous completion of one bank and drain of the other in the same cycle: both take effect.
- flush:
  - sets wr_idx←0 and clears the fill-bank sat bit; full banks are untouched.
  - If flush and an accept occur in the same cycle, flush wins and the element is dropped.
- Reset (async, rst_n=0): wr_bank=rd_bank=0, wr_idx=0, full=0, bank contents and sat bits 0. Resulting outputs: in_ready=1, out_valid=0, out_vec=0, out_sat=0.
- Reset mid-vector discards all partial and full data; there is no recovery.

## Timing
- Latency: the N_OUT-th accepted element at edge t → out_valid=1 after edge t (visible in cycle t+1).
- Throughput: one element per cycle sustained. No bubble between vectors as long as downstream drains within N_OUT cycles.
- Handshake stability: while out_valid && !out_ready, out_vec and out_sat stay constant.
- With both banks full, in_ready=0. After the draining edge, in_ready=1 in the next cycle.
- in_ready never depends on in_valid.
- out_valid never falls without a handshake except on reset.

## Test plan
- SHIFT=8, RELU_EN=1, N_OUT=16:
  - Feed in_acc = 384, 383, -384, 0, 256·k for k=4..15.
  - → out_vec elements 2, 1, 0, 0, 4..15; out_sat=0; out_valid rises one cycle after the 16th accept.
- Saturation:
  - Feed 0x7FFFFFFF as element 5 and 0x80000000 as element 6 with RELU_EN=0.
  - → element 5 = 32767, element 6 = -32768, out_sat=1.
  - The next vector, all zeros, shows out_sat=0.
- Backpressure:
  - Hold out_ready=0 and drive in_valid=1 continuously.
  - → exactly 32 accepts, then in_ready=0.
  - Raise out_ready for one cycle → vector A drains, in_ready=1 the next cycle, out_vec switches to vector B unchanged.
- Streaming:
  - Drive out_ready=1 and in_valid=1 for 64 cycles.
  - → 4 vectors, no in_ready deassertion, order and contents preserved.
- Flush:
  - Accept 7 elements, assert flush together with an 8th in_valid, then feed 16 values 1..16.
  - → the first vector out is 1..16; the 8th element is lost.
- Reset:
  - Assert rst_n=0 while one bank is full and wr_idx=9.
  - → out_valid=0, out_vec=0 and in_ready=1 immediately; the next 16 accepts form a clean vector.
